// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: per-register pending-write scoreboard, memory-wait freeze
// and multi-cycle branch flush. Optional perf counters: define HAZARD_PERF_CNT_EN.
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W          = 2,
    parameter int DATA_FORWARDING     = 0,
    parameter int BRANCH_FLUSH_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       use_rs_ID,
    input  logic                       use_rt_ID,
    input  logic [REG_ADDR_W-1:0]      rs_ID,
    input  logic [REG_ADDR_W-1:0]      rt_ID,
    input  logic                       reads_in_ID,
    input  logic                       reg_write_ID,
    input  logic                       mem_read_ID,
    input  logic [REG_ADDR_W-1:0]      dest_ID,
    input  logic                       jump_miss,
    input  logic                       i_branch_miss,
    input  logic                       mem_stall,
    output logic                       stall_IFID,
    output logic                       flush_IFID,
    output logic                       flush_IDEX,
    output logic                       pc_write,
    output logic                       ir_write,
    output logic [2**REG_ADDR_W-1:0]   pending_vec
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]                stall_cycles,
    output logic [15:0]                flush_events
`endif
);

    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam int FCNT_W   = $clog2(BRANCH_FLUSH_CYCLES) + 1;
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(BRANCH_FLUSH_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

    // state | meaning
    // IDLE  | no branch flush in progress
    // FLUSH | extending a conditional-branch flush, fcnt cycles left
    typedef enum logic {IDLE, FLUSH} state_t;

    state_t              state, state_next;
    logic [FCNT_W-1:0]   fcnt, fcnt_next;

    logic [1:0]          cnt      [NUM_REGS];
    logic [1:0]          cnt_next [NUM_REGS];
    logic [NUM_REGS-1:0] ld, ld_next;

    logic rs_busy, rt_busy;
    logic rs_ld_ex, rt_ld_ex;
    logic rs_haz, rt_haz;
    logic data_stall;
    logic branch_active;
    logic issue;

    assign rs_busy  = (cnt[rs_ID] != 2'd0);
    assign rt_busy  = (cnt[rt_ID] != 2'd0);
    assign rs_ld_ex = ld[rs_ID] && (cnt[rs_ID] == 2'd2);
    assign rt_ld_ex = ld[rt_ID] && (cnt[rt_ID] == 2'd2);

    // With forwarding only a load still in EX blocks an EX consumer; an ID-stage
    // consumer (register jump) cannot be forwarded to and waits for WB.
    assign rs_haz = (DATA_FORWARDING != 0) ? (rs_ld_ex | (reads_in_ID & rs_busy)) : rs_busy;
    assign rt_haz = (DATA_FORWARDING != 0) ? rt_ld_ex : rt_busy;

    assign data_stall    = (use_rs_ID & rs_haz) | (use_rt_ID & rt_haz);
    assign branch_active = i_branch_miss | (state == FLUSH);

    always_comb begin
        stall_IFID = 1'b0;
        flush_IFID = 1'b0;
        flush_IDEX = 1'b0;
        pc_write   = 1'b1;
        ir_write   = 1'b1;
        if (reset) begin
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
        end else if (mem_stall) begin
            stall_IFID = 1'b1;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
        end else if (branch_active) begin
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
        end else if (data_stall) begin
            stall_IFID = 1'b1;
            flush_IDEX = 1'b1;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
        end else if (jump_miss) begin
            flush_IFID = 1'b1;
        end
    end

    assign issue = reg_write_ID & ~data_stall & ~flush_IDEX & ~mem_stall;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_next[r] = cnt[r];
            if (!mem_stall && (cnt[r] != 2'd0)) begin
                cnt_next[r] = cnt[r] - 2'd1;
            end
        end
        ld_next = ld;
        if (issue) begin
            cnt_next[dest_ID] = 2'd2;
            ld_next[dest_ID]  = mem_read_ID;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= 2'd0;
            end
            ld <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_next[r];
            end
            ld <= ld_next;
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_vec[r] = (cnt[r] != 2'd0);
        end
    end

    always_comb begin
        state_next = state;
        fcnt_next  = fcnt;
        if (!mem_stall) begin
            case (state)
                IDLE: begin
                    if (i_branch_miss && (BRANCH_FLUSH_CYCLES > 1)) begin
                        state_next = FLUSH;
                        fcnt_next  = FCNT_LOAD;
                    end
                end
                FLUSH: begin
                    if (i_branch_miss) begin
                        fcnt_next = FCNT_LOAD;
                    end else if (fcnt == FCNT_ONE) begin
                        state_next = IDLE;
                        fcnt_next  = '0;
                    end else begin
                        fcnt_next = fcnt - FCNT_ONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    fcnt_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            state <= state_next;
            fcnt  <= fcnt_next;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic stall_sel;
    logic flush_accept;

    assign stall_sel    = ~reset & ~mem_stall & ~branch_active & data_stall;
    assign flush_accept = ~reset & ~mem_stall &
                          ((i_branch_miss & (state == IDLE)) |
                           (~branch_active & ~data_stall & jump_miss));

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_sel && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (flush_accept && (flush_events != 16'hFFFF)) begin
                flush_events <= flush_events + 16'd1;
            end
        end
    end
`endif

endmodule
